// File: rtl/sa_cache_ctrl.sv
// Set-associative write-back/write-allocate data cache with true-LRU replacement
// and a miss FSM for dirty-victim writeback followed by line refill.
module sa_cache_ctrl #(
    parameter int unsigned NUM_SETS    = 4,
    parameter int unsigned NUM_WAYS    = 4,
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic [1:0]                cpu_size,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_ready,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [32*BLOCK_WORDS-1:0] mem_wdata,
    input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
    input  logic                      mem_ack,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
);
    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned WOFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned AGE_W  = $clog2(NUM_WAYS);
    localparam int unsigned OFF_W  = 2 + WOFF_W;
    localparam int unsigned TAG_W  = 30 - IDX_W - WOFF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t state;

    logic [31:0]         data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [AGE_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];

    logic [AGE_W-1:0] victim_q;
    logic [IDX_W-1:0] miss_idx_q;
    logic [TAG_W-1:0] miss_tag_q;

    logic [1:0]        byte_off;
    logic [WOFF_W-1:0] word_off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;

    assign byte_off = cpu_addr[1:0];
    assign word_off = cpu_addr[OFF_W-1:2];
    assign idx      = cpu_addr[OFF_W +: IDX_W];
    assign tag      = cpu_addr[31 -: TAG_W];

    // Tag lookup in the indexed set; at most one way can match.
    logic             tag_match;
    logic [AGE_W-1:0] hit_way;
    logic             hit;

    always_comb begin
        tag_match = 1'b0;
        hit_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                tag_match = 1'b1;
                hit_way   = AGE_W'(w);
            end
        end
    end

    assign hit = cpu_req && (state == S_IDLE) && tag_match;

    logic [31:0]      rd_word;
    logic [AGE_W-1:0] hit_age;

    assign rd_word   = data_q[idx][hit_way][word_off];
    assign hit_age   = age_q[idx][hit_way];
    assign cpu_ready = hit;
    assign cpu_rdata = hit ? rd_word : 32'd0;

    // Byte enables for a store; unsupported size/offset pairs give no enables.
    logic [3:0]  be;
    logic [31:0] be_mask;
    logic [31:0] wdata_sh;
    logic [31:0] store_word;
    logic        store_en;

    always_comb begin
        be = 4'b0000;
        case (cpu_size)
            2'b00:   be = 4'b0001 << byte_off;
            2'b01:   if (byte_off != 2'd3) be = 4'b0011 << byte_off;
            2'b10:   if (byte_off == 2'd0) be = 4'b1111;
            default: be = 4'b0000;
        endcase
        be_mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wdata_sh   = cpu_wdata << {byte_off, 3'b000};
        store_word = (rd_word & ~be_mask) | (wdata_sh & be_mask);
    end

    assign store_en = hit && cpu_we && (be != 4'b0000);

    // Victim: lowest-index invalid way, otherwise the LRU way.
    logic [AGE_W-1:0] victim;
    logic             found_invalid;

    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_invalid && !valid_q[idx][w]) begin
                victim        = AGE_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[idx][w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
            end
        end
    end

    logic fill_done;
    assign fill_done = (state == S_FILL) && mem_req && mem_ack;

    // Miss FSM, tag-state bookkeeping and counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
            victim_q   <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req && !tag_match) begin
                        miss_count <= miss_count + 32'd1;
                        victim_q   <= victim;
                        miss_idx_q <= idx;
                        miss_tag_q <= tag;
                        mem_req    <= 1'b1;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            state    <= S_WB;
                            mem_we   <= 1'b1;
                            mem_addr <= {tag_q[idx][victim], idx, {OFF_W{1'b0}}};
                        end else begin
                            state    <= S_FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {tag, idx, {OFF_W{1'b0}}};
                        end
                    end else if (hit) begin
                        hit_count <= hit_count + 32'd1;
                        for (int w = 0; w < NUM_WAYS; w++) begin
                            if (AGE_W'(w) == hit_way)
                                age_q[idx][w] <= '0;
                            else if (age_q[idx][w] < hit_age)
                                age_q[idx][w] <= AGE_W'(age_q[idx][w] + 1'b1);
                        end
                        if (store_en) dirty_q[idx][hit_way] <= 1'b1;
                    end
                end
                S_WB: begin
                    if (mem_req && mem_ack) begin
                        state    <= S_FILL;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_addr <= {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                    end
                end
                S_FILL: begin
                    // Coming from WB the request drops for one cycle before refill starts.
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req                        <= 1'b0;
                        valid_q[miss_idx_q][victim_q] <= 1'b1;
                        dirty_q[miss_idx_q][victim_q] <= 1'b0;
                        state                          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line data and tags; no reset needed since valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (fill_done) begin
                tag_q[miss_idx_q][victim_q] <= miss_tag_q;
                for (int k = 0; k < BLOCK_WORDS; k++)
                    data_q[miss_idx_q][victim_q][k] <= mem_rdata[32*k +: 32];
            end else if (store_en) begin
                data_q[idx][hit_way][word_off] <= store_word;
            end
        end
    end

    always_comb begin
        mem_wdata = '0;
        if (mem_we) begin
            for (int k = 0; k < BLOCK_WORDS; k++)
                mem_wdata[32*k +: 32] = data_q[miss_idx_q][victim_q][k];
        end
    end

endmodule

// File: doc/sa_cache_ctrl.md
Name: sa_cache_ctrl

Overview:
- Parametrised set-associative, write-back, write-allocate data cache with true-LRU replacement.
- Includes an integrated miss FSM that does dirty-victim writeback and then line refill over a valid/ack memory handshake.
- Sits between the OTTER memory stage (CPU side) and the block-wide data memory.
- Also provides hit/miss performance counters.

Parameters:
NUM_SETS, 4, number of sets; power of 2, ≥2
NUM_WAYS, 4, ways per set; power of 2, ≥2
BLOCK_WORDS, 4, 32-bit words per line; power of 2, ≥2
Derived: IDX_W=log2(NUM_SETS), WOFF_W=log2(BLOCK_WORDS), TAG_W=30-IDX_W-WOFF_W, AGE_W=log2(NUM_WAYS)

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous, active-high reset
cpu_req  in  1  access request; held with all cpu_* inputs stable until cpu_ready
cpu_we  in  1  1=store, 0=load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned
cpu_size  in  2  00 byte, 01 half, 10 word
cpu_rdata  out  32  full aligned word at cpu_addr[31:2]; valid when cpu_ready&&!cpu_we
cpu_ready  out  1  access completes this cycle
mem_req  out  1  memory transaction request
mem_we  out  1  1=writeback, 0=refill
mem_addr  out  32  line-aligned address (low 2+WOFF_W bits zero)
mem_wdata  out  32*BLOCK_WORDS  victim line; word 0 in bits [31:0]
mem_rdata  in  32*BLOCK_WORDS  refill line; sampled on the mem_ack cycle
mem_ack  in  1  one-cycle completion pulse
hit_count  out  32  hits counted
miss_count  out  32  misses counted

Behaviour:
- Reset:
  - All valid and dirty bits are cleared.
  - In every set, way w gets age w (0 = MRU).
  - FSM goes to IDLE; counters go to 0.
  - cpu_ready=0, mem_req=0, mem_we=0, mem_addr=0, cpu_rdata=0.
  - RST overrides everything, including mid-writeback/refill; the in-flight memory transaction is abandoned and any late mem_ack is ignored.
- Address split: byte_off=[1:0], word_off=[2+WOFF_W-1:2], index=next IDX_W bits, tag=remaining upper bits.
- Hit: cpu_req && a way in the indexed set is valid with a matching tag. Multiple matches cannot occur by construction.
- States:
  - IDLE, hit: cpu_ready=1 combinationally, 0-cycle latency. cpu_rdata comes from the hit way.
    - Store updates the addressed bytes at the posedge and sets dirty.
    - Hit way becomes age 0; ways younger than it age by +1; others are unchanged.
    - hit_count increments.
  - IDLE, miss: cpu_ready=0. Victim is the lowest-index invalid way, else the way with age NUM_WAYS-1. Victim index is registered.
    - miss_count increments once per miss; a replay hit after refill also counts as a hit.
    - Next state is WB if the victim is valid&&dirty, else FILL.
  - WB: mem_req=1, mem_we=1, mem_addr={victim tag,index,0}, mem_wdata=victim line, all held stable. On mem_ack: go to FILL.
  - FILL: mem_req=1, mem_we=0, mem_addr={cpu tag,index,0}. On mem_ack: write the line from mem_rdata, set valid=1, dirty=0, store the tag (LRU not touched), then go to IDLE. The request replays as a hit one cycle after the ack.
  - mem_ack outside WB/FILL is ignored. mem_req deasserts the cycle after the ack.
- Store merge by {size,byte_off}:
  - byte: any offset.
  - half: offsets 0,1,2.
  - word: offset 0.
  - Any other combination (half@3, word@1..3, size 11) is a no-op store: cpu_ready still completes; no data change; no dirty set; LRU and hit counter still update.
- Loads return the whole word; extension is done downstream.
- Counters wrap at 2^32 with no saturation.
- cpu_req dropped mid-miss is illegal; the completed refill still installs.

Test Plan:
- RST, then load 0x100 → miss_count=1; FILL with mem_addr=0x100, mem_we=0; ack with mem_rdata words {A0,A1,A2,A3} → next cycle cpu_ready=1, cpu_rdata=A0; load 0x104 → same-cycle hit, A1, hit_count=2.
- Store word 0xDEADBEEF to 0x108, then sb 0x55 to 0x10B → load 0x108 returns 0x55ADBEEF; line dirty.
- Fill set 0 with 5 distinct tags (NUM_WAYS=4; addrs 0x000,0x040,0x080,0x0C0,0x100), touching 0x000 again before the 5th → 0x040 is evicted; a reload of 0x000 hits.
- Dirty victim: write 0x040 then force its eviction → WB with mem_addr=0x040, mem_we=1, mem_wdata carries the written word, held 3 cycles until a delayed ack; then FILL, then IDLE.
- Misaligned sh at offset 3 and sw at offset 2 → cpu_ready=1, data unchanged, no WB on a later eviction.
- Assert RST during WB with ack pending → next cycle mem_req=0, all lines invalid, counters 0; a late mem_ack has no effect.
